// File: rtl/capture_ctrl.sv
// capture_ctrl: dclk-domain sequencer for the LVDS capture -> FIFO record path
//   dclk      capture word clock, all logic on rising edge
//   mr        master reset, asynchronous, active low
//   locked    DCM lock (async, 2-flop synchronised)
//   start_n   record request, active-low level (async, 2-flop sync + falling-edge detect)
//   rec_len   words per record, 0 = 2^CNT_W; trig_en waits for a trig rising edge (both sampled on start)
//   trig      external trigger (dclk domain); fifo_full storage full flag (dclk domain)
//   fifo_wen  registered FIFO write enable
//   busy      start accepted until DONE; done held until next start
//   err       00 ok, 01 truncated by fifo_full, 10 lock lost (valid while done)
//   wr_count  words written in current/last record
module capture_ctrl #(
  parameter int CNT_W      = 14,
  parameter int SETTLE_CYC = 16
) (
  input  logic             dclk,
  input  logic             mr,
  input  logic             locked,
  input  logic             start_n,
  input  logic [CNT_W-1:0] rec_len,
  input  logic             trig_en,
  input  logic             trig,
  input  logic             fifo_full,
  output logic             fifo_wen,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] wr_count
);
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, SETTLE, ARMED, CAPTURE, DONE} state_t;
  state_t           state_q;
  logic [1:0]       lock_q;
  logic [2:0]       start_q;
  logic             trig_d_q, trig_en_q, wen_q, busy_q, done_q;
  logic [1:0]       err_q;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic [7:0]       settle_q;
  logic             locked_s, start_ev, wr, last;
  assign locked_s = lock_q[1];
  assign start_ev = start_q[2] & ~start_q[1];
  // a word is stored on any edge where the enable is high and the FIFO is not full
  assign wr       = wen_q & ~fifo_full;
  // len 0 gives all-ones here, so the record runs until the counter wraps
  assign last     = cnt_q == len_q - CNT_W'(1);
  assign fifo_wen = wen_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wr_count = cnt_q;
  always_ff @(posedge dclk or negedge mr)
    if (!mr) begin
      state_q   <= IDLE;
      lock_q    <= '0;
      start_q   <= '1;
      trig_d_q  <= 1'b0;
      trig_en_q <= 1'b0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 2'b00;
      len_q     <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
    end else begin
      lock_q   <= {lock_q[0], locked};
      start_q  <= {start_q[1:0], start_n};
      trig_d_q <= trig;
      case (state_q)
        IDLE, DONE:
          if (start_ev) begin
            state_q   <= locked_s ? SETTLE : WAIT_LOCK;
            len_q     <= rec_len;
            trig_en_q <= trig_en;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 2'b00;
            cnt_q     <= '0;
            settle_q  <= '0;
          end
        WAIT_LOCK:
          if (locked_s) begin
            state_q  <= SETTLE;
            settle_q <= '0;
          end
        SETTLE:
          if (!locked_s) state_q <= WAIT_LOCK;
          else if (settle_q == 8'(SETTLE_CYC - 1)) begin
            state_q <= trig_en_q ? ARMED : CAPTURE;
            wen_q   <= ~trig_en_q;
          end else settle_q <= settle_q + 8'd1;
        ARMED:
          if (!locked_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 2'b10;
          end else if (trig & ~trig_d_q) begin
            state_q <= CAPTURE;
            wen_q   <= 1'b1;
          end
        CAPTURE: begin
          if (wr) cnt_q <= cnt_q + CNT_W'(1);
          // lock loss outranks completion and full; the word on this edge still counts
          if (!locked_s || (wr && last) || fifo_full) begin
            state_q <= DONE;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= !locked_s ? 2'b10 : (wr && last) ? 2'b00 : 2'b01;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
